mult_hilo_ctrl: RTL and testbench

Issue and writeback controller for the unsigned multiply path of the MIPS datapath. It accepts MULTU, MTHI, MTLO, MFHI and MFLO requests from the execute stage and drives the pipelined multiplier. It captures the 64-bit product into the architectural HI/LO registers after the multiplier's fixed latency, and holds the pipeline off with a stall while a product is in flight.

---
 rtl/mult_pkg.sv | 15 +
 rtl/multiplier_pipelined.sv | 42 ++++
 rtl/mult_hilo_ctrl.sv | 113 +++++++++++
 tb/tb_mult_hilo_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the HI/LO multiply controller.
package mult_pkg;

  localparam int WIDTH    = 32;
  localparam int MULT_LAT = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hilo_state_e;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

endpackage

// File: rtl/multiplier_pipelined.sv
// Unsigned WIDTH x WIDTH multiplier with STAGES enabled register stages.
module multiplier_pipelined #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  logic [2*WIDTH-1:0] pipe_r [STAGES];
  logic [2*WIDTH-1:0] a_ext_s;
  logic [2*WIDTH-1:0] b_ext_s;

  assign a_ext_s = {{WIDTH{1'b0}}, A};
  assign b_ext_s = {{WIDTH{1'b0}}, B};

  // Product pipeline: multiply into stage 0, shift forward while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_r[i] <= '0;
      end
    end else if (en_in) begin
      pipe_r[0] <= a_ext_s * b_ext_s;
      for (int i = 1; i < STAGES; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_r[i] <= pipe_r[i];
      end
    end
  end

  assign {out_hi, out_lo} = pipe_r[STAGES-1];

endmodule

// File: rtl/mult_hilo_ctrl.sv
// MULTU/MTHI/MTLO/MFHI/MFLO controller: issues to the pipelined multiplier,
// writes the product into HI/LO after MULT_LAT edges and stalls requests meanwhile.
module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH    = mult_pkg::WIDTH,
  parameter int MULT_LAT = mult_pkg::MULT_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CNT_W = $clog2(MULT_LAT + 1);
  // The operand registers count as the first latency edge, so the
  // multiplier itself carries one stage fewer than MULT_LAT.
  localparam int MUL_STAGES = MULT_LAT - 1;

  hilo_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             busy_r;
  logic             done_r;
  logic             en_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;

  assign en_s = (state_r == BUSY);

  multiplier_pipelined #(
    .WIDTH  (WIDTH),
    .STAGES (MUL_STAGES)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .en_in  (en_s),
    .A      (a_r),
    .B      (b_r),
    .out_hi (mul_hi_s),
    .out_lo (mul_lo_s)
  );

  // Issue/writeback FSM together with its counter, operands and HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            cnt_r   <= CNT_W'(MULT_LAT);
            busy_r  <= 1'b1;
            state_r <= BUSY;
          end else begin
            if (mthi) begin
              hi_r <= wdata;
            end
            if (mtlo) begin
              lo_r <= wdata;
            end
          end
        end
        BUSY: begin
          if (cnt_r == CNT_W'(1)) begin
            hi_r    <= mul_hi_s;
            lo_r    <= mul_lo_s;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign stall   = busy_r & (start | mthi | mtlo | rd_req);
  assign rd_data = (rd_sel == RD_HI) ? hi_r : lo_r;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl: issued products are queued, a monitor
// pops and compares HI:LO on every done pulse; directed cases cover timing.
module tb_mult_hilo_ctrl;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;
  logic        done;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int cyc       = 0;
  int accept_cyc = 0;
  logic [63:0] exp_q[$];

  logic        mon_sel_save;
  logic [31:0] mon_hi;
  logic [31:0] mon_lo;
  logic [63:0] mon_exp;

  mult_hilo_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .rd_req  (rd_req),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .busy    (busy),
    .stall   (stall),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: on each done pulse read HI and LO through the port and compare.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (done === 1'b1) begin
        done_cnt++;
        mon_sel_save = rd_sel;
        rd_sel = RD_HI;
        #1 mon_hi = rd_data;
        rd_sel = RD_LO;
        #1 mon_lo = rd_data;
        rd_sel = mon_sel_save;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_without_start actual=done expected=no_done");
        end else begin
          mon_exp = exp_q.pop_front();
          check("product", {mon_hi, mon_lo}, mon_exp);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input bit hold);
    int n;
    a = ia;
    b = ib;
    start = 1'b1;
    n = 0;
    @(negedge clk);
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (stall) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=stalled expected=accepted");
    end
    exp_q.push_back(64'(ia) * 64'(ib));
    @(posedge clk);
    accept_cyc = cyc;
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles, output int done_seen);
    busy_cycles = 0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_seen = 1;
        break;
      end
    end
  endtask

  task automatic read_at(input logic sel, input logic [31:0] exp, input string name);
    @(posedge clk);
    #1;
    rd_req = 1'b1;
    rd_sel = sel;
    @(negedge clk);
    check(name, rd_data, exp);
    check({name, "_stall"}, stall, 1'b0);
  endtask

  initial begin
    int bc;
    int ds;
    int ns;
    int d0;
    int c0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    wdata = '0; rd_req = 1'b0; rd_sel = RD_LO;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    read_at(RD_LO, 32'h0, "reset_lo");
    read_at(RD_HI, 32'h0, "reset_hi");
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    rd_req = 1'b0;

    // Max operands: busy for exactly MULT_LAT cycles, single done pulse
    @(posedge clk); #1;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(bc, ds);
    check("busy_cycles", bc, 3);
    check("done_seen", ds, 1);
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    read_at(RD_HI, 32'hFFFF_FFFE, "max_hi");
    read_at(RD_LO, 32'h0000_0001, "max_lo");
    rd_req = 1'b0;

    // Read held during busy stalls, first unstalled read returns new product
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      issue(32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0);
      rd_req = 1'b1;
      rd_sel = (k == 0) ? RD_HI : RD_LO;
      ns = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (stall) ns++;
        else break;
      end
      check("stall_cycles", ns, 3);
      check("stall_end_done", done, 1'b1);
      check("rd_after_stall", rd_data, (k == 0) ? 32'hFFFF_FFFC : 32'h0000_0004);
      @(posedge clk); #1;
      rd_req = 1'b0;
    end

    // start has priority over a same-cycle mthi
    @(posedge clk); #1;
    mthi = 1'b1;
    wdata = 32'hDEAD_BEEF;
    issue(32'd2, 32'd3, 1'b0);
    mthi = 1'b0;
    wait_done(bc, ds);
    check("prio_done_seen", ds, 1);
    read_at(RD_HI, 32'h0, "prio_hi");
    read_at(RD_LO, 32'd6, "prio_lo");

    // Move written at an edge is seen by reads only in the following cycle
    @(posedge clk); #1;
    mtlo = 1'b1;
    wdata = 32'h1234_5678;
    rd_sel = RD_LO;
    @(negedge clk);
    check("mtlo_same_cycle", rd_data, 32'd6);
    @(posedge clk); #1;
    mtlo = 1'b0;
    @(negedge clk);
    check("mtlo_next_cycle", rd_data, 32'h1234_5678);
    @(posedge clk); #1;
    mthi = 1'b1;
    mtlo = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    rd_req = 1'b0;
    read_at(RD_HI, 32'hCAFE_F00D, "both_hi");
    read_at(RD_LO, 32'hCAFE_F00D, "both_lo");
    rd_req = 1'b0;

    // Reset mid-operation discards the in-flight product
    @(posedge clk); #1;
    issue(32'h0001_0000, 32'h0001_0000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_done_count", done_cnt - d0, 0);
    check("abort_busy", busy, 1'b0);
    read_at(RD_HI, 32'h0, "abort_hi");
    read_at(RD_LO, 32'h0, "abort_lo");
    rd_req = 1'b0;

    // Random back-to-back issue at maximum rate with start held through stall
    d0 = done_cnt;
    @(posedge clk); #1;
    issue($urandom, $urandom, 1'b1);
    c0 = accept_cyc;
    for (int i = 1; i < 1000; i++) begin
      issue($urandom, $urandom, 1'b1);
    end
    start = 1'b0;
    check("issue_spacing", accept_cyc - c0, 999 * (MULT_LAT + 1));
    wait_done(bc, ds);
    @(negedge clk);
    @(negedge clk);
    check("rand_done_count", done_cnt - d0, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
